run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
- Program-run controller between the host handshake (Start/Ack) and the single-cycle core.
- On a host start it selects a program entry address, holds the core in reset for one cycle, then enables it.
- It counts executed cycles, detects the core's halt, enforces a watchdog limit, and reports done or timeout to the host.
- The core's PC load, run-enable and halt signals connect here instead of directly to the host.

Parameters:
- PC_W, 10, width of program-counter / entry address.
- CYC_W, 16, width of cycle counter.
- MAX_CYCLES, 16'hFFFF, watchdog limit on RUN cycles per program (must be >= 1).
- BASE0, 10'd0, entry address for program 0.
- BASE1, 10'd256, entry address for program 1.
- BASE2, 10'd512, entry address for program 2.
- BASE3, 10'd768, entry address for program 3.

Ports:
- Clk  in  1  clock; posedge used throughout.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  host run request; a rising edge launches a program.
- PgmSel  in  2  program index; sampled on the launching edge.
- CoreHalt  in  1  core halt flag; examined only in RUN.
- CoreReset  out  1  high = core PC forced to StartPC.
- CoreRun  out  1  high = core may advance and write state.
- StartPC  out  PC_W  entry address presented to the core.
- Ack  out  1  program finished (normal or timeout).
- Timeout  out  1  last program hit the watchdog limit.
- CycleCt  out  CYC_W  RUN cycles of the current/last program.
- RunCount  out  8  programs completed normally; saturates at 255.

Behaviour:
- One clock, one synchronous active-high reset; no other state-clearing input.
- States: IDLE, INIT, RUN, DONE, FAULT.
- Outputs are Moore-decoded from registered state:
  - CoreReset=1 in IDLE and INIT;
  - CoreRun=1 only in RUN;
  - Ack=1 in DONE and FAULT;
  - Timeout=1 only in FAULT.
- Reset (any state, including mid-RUN), values after the edge:
  - state=IDLE;
  - StartPC=BASE0, CycleCt=0, RunCount=0;
  - start_q=0;
  - CoreReset=1, CoreRun=0, Ack=0, Timeout=0.
- Launch event: Start=1 & start_q=0, where start_q is the registered previous Start. Start held high never relaunches.
- Launch is accepted only in IDLE, DONE or FAULT. On acceptance at edge N:
  - state=INIT;
  - StartPC=BASE[PgmSel];
  - CycleCt=0;
  - Ack and Timeout drop in the cycle after edge N.
- Launch events in INIT or RUN are ignored; StartPC is unchanged.
- INIT lasts exactly one cycle, then RUN. The first instruction executes in the cycle after edge N+1.
- RUN: CycleCt increments by 1 on every RUN edge, including the halt cycle. Let next = CycleCt+1.
  - CoreHalt=1 -> DONE, CycleCt=next, RunCount=min(RunCount+1,255).
  - CoreHalt=0 and next==MAX_CYCLES -> FAULT, CycleCt=MAX_CYCLES; RunCount unchanged.
  - Halt and limit in the same cycle -> DONE; halt wins, Timeout stays 0.
  - Otherwise stay in RUN.
- DONE/FAULT:
  - core frozen (CoreRun=0, CoreReset=0) so host can inspect memory;
  - CycleCt and StartPC held;
  - leave only on launch event or Reset.
- CoreHalt is ignored outside RUN; a halt high during INIT does not count.
- CycleCt arithmetic is unsigned, CYC_W bits; it never wraps because the watchdog bounds it.

Test Plan:
1. Reset held 2 cycles, then released -> CoreReset=1, CoreRun=0, Ack=0, Timeout=0, CycleCt=0, RunCount=0, StartPC=BASE0.
2. Start 0->1 with PgmSel=2, CoreHalt raised in 5th RUN cycle -> INIT for one cycle with StartPC=512; CoreRun high 5 cycles; then Ack=1, Timeout=0, CycleCt=5, RunCount=1.
3. MAX_CYCLES=20, launch, CoreHalt never asserted -> CoreRun high exactly 20 cycles; then FAULT with Ack=1, Timeout=1, CycleCt=20, RunCount=0.
4. MAX_CYCLES=20, CoreHalt=1 exactly in 20th RUN cycle -> DONE, Timeout=0, CycleCt=20, RunCount=1.
5. Start held high through DONE; pulse during RUN -> no relaunch while held, run unaffected by pulse; drop then raise Start with PgmSel=1 -> INIT, StartPC=256, Ack drops.
6. Reset asserted in 3rd RUN cycle after a prior completed run -> next cycle IDLE, RunCount=0, CycleCt=0, CoreRun=0, Ack=0.

Source files
------------

// File: rtl/run_sequencer.sv
// Program-run controller: launches the core on a host start edge, counts RUN
// cycles, and reports halt (done) or watchdog expiry (timeout) back to the host.
module run_sequencer #(
    parameter int unsigned           PC_W       = 10,
    parameter int unsigned           CYC_W      = 16,
    parameter logic [CYC_W-1:0]      MAX_CYCLES = 16'hFFFF,
    parameter logic [PC_W-1:0]       BASE0      = 10'd0,
    parameter logic [PC_W-1:0]       BASE1      = 10'd256,
    parameter logic [PC_W-1:0]       BASE2      = 10'd512,
    parameter logic [PC_W-1:0]       BASE3      = 10'd768
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       PgmSel,
    input  logic             CoreHalt,
    output logic             CoreReset,
    output logic             CoreRun,
    output logic [PC_W-1:0]  StartPC,
    output logic             Ack,
    output logic             Timeout,
    output logic [CYC_W-1:0] CycleCt,
    output logic [7:0]       RunCount
);

    // state | meaning
    // IDLE  | core held in reset, waiting for first launch
    // INIT  | one cycle of core reset with StartPC loaded
    // RUN   | core executing, cycle counter and watchdog active
    // DONE  | core halted normally, frozen for host inspection
    // FAULT | watchdog expired, frozen for host inspection
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic             start_q;
    logic [PC_W-1:0]  start_pc_q;
    logic [CYC_W-1:0] cyc_q;
    logic [7:0]       run_cnt_q;
    logic             core_reset_q;
    logic             core_run_q;
    logic             ack_q;
    logic             timeout_q;

    logic             launch;
    logic [CYC_W-1:0] cyc_next;
    logic [PC_W-1:0]  base_sel;

    assign launch   = Start & ~start_q;
    assign cyc_next = cyc_q + CYC_ONE;

    always_comb begin
        base_sel = BASE0;
        case (PgmSel)
            2'd0: base_sel = BASE0;
            2'd1: base_sel = BASE1;
            2'd2: base_sel = BASE2;
            2'd3: base_sel = BASE3;
            default: base_sel = BASE0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            start_pc_q   <= BASE0;
            cyc_q        <= '0;
            run_cnt_q    <= '0;
            core_reset_q <= 1'b1;
            core_run_q   <= 1'b0;
            ack_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            start_q <= Start;
            case (state_q)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (launch) begin
                        state_q      <= S_INIT;
                        start_pc_q   <= base_sel;
                        cyc_q        <= '0;
                        core_reset_q <= 1'b1;
                        core_run_q   <= 1'b0;
                        ack_q        <= 1'b0;
                        timeout_q    <= 1'b0;
                    end
                end
                S_INIT: begin
                    state_q      <= S_RUN;
                    core_reset_q <= 1'b0;
                    core_run_q   <= 1'b1;
                end
                S_RUN: begin
                    cyc_q <= cyc_next;
                    // A halt on the watchdog's last cycle still counts as a normal finish.
                    if (CoreHalt) begin
                        state_q    <= S_DONE;
                        core_run_q <= 1'b0;
                        ack_q      <= 1'b1;
                        if (run_cnt_q != 8'd255) begin
                            run_cnt_q <= run_cnt_q + 8'd1;
                        end
                    end else if (cyc_next == MAX_CYCLES) begin
                        state_q    <= S_FAULT;
                        core_run_q <= 1'b0;
                        ack_q      <= 1'b1;
                        timeout_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_reset_q <= 1'b1;
                    core_run_q   <= 1'b0;
                    ack_q        <= 1'b0;
                    timeout_q    <= 1'b0;
                end
            endcase
        end
    end

    assign CoreReset = core_reset_q;
    assign CoreRun   = core_run_q;
    assign StartPC   = start_pc_q;
    assign Ack       = ack_q;
    assign Timeout   = timeout_q;
    assign CycleCt   = cyc_q;
    assign RunCount  = run_cnt_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: table of programs, hand-built corner sequences and
// randomized runs checked against a per-program outcome model.
module tb_run_sequencer;

    localparam int MAXC = 20;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  PgmSel = 2'd0;
    logic        CoreHalt = 1'b0;
    logic        CoreReset, CoreRun, Ack, Timeout;
    logic [9:0]  StartPC;
    logic [15:0] CycleCt;
    logic [7:0]  RunCount;

    int checks = 0;
    int errors = 0;
    int model_runs = 0;

    run_sequencer #(.MAX_CYCLES(16'd20)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .PgmSel(PgmSel),
        .CoreHalt(CoreHalt), .CoreReset(CoreReset), .CoreRun(CoreRun),
        .StartPC(StartPC), .Ack(Ack), .Timeout(Timeout),
        .CycleCt(CycleCt), .RunCount(RunCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] sel;
        int         halt_at;
        int         exp_pc;
        int         exp_ct;
        bit         exp_to;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_core_reset"}, 32'(CoreReset), 1);
        chk({tag, "_core_run"}, 32'(CoreRun), 0);
        chk({tag, "_ack"}, 32'(Ack), 0);
        chk({tag, "_timeout"}, 32'(Timeout), 0);
        chk({tag, "_cycle_ct"}, 32'(CycleCt), 0);
        chk({tag, "_run_count"}, 32'(RunCount), 0);
        chk({tag, "_start_pc"}, 32'(StartPC), 0);
    endtask

    // One full program: launch edge, INIT check, RUN with halt in RUN cycle
    // halt_at (0 = never), then outcome checks.
    task automatic run_prog(input logic [1:0] sel, input int halt_at, input bit noise,
                            input int exp_pc, input int exp_ct, input bit exp_to);
        int k;
        int guard;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Start  = 1'b1;
        PgmSel = sel;
        @(negedge Clk);
        chk("init_core_reset", 32'(CoreReset), 1);
        chk("init_core_run", 32'(CoreRun), 0);
        chk("init_start_pc", 32'(StartPC), 32'(exp_pc));
        chk("init_ack", 32'(Ack), 0);
        chk("init_timeout", 32'(Timeout), 0);
        chk("init_cycle_ct", 32'(CycleCt), 0);
        PgmSel   = 2'(~sel);
        CoreHalt = noise ? 1'b1 : 1'b0;
        k = 0;
        guard = 0;
        forever begin
            @(negedge Clk);
            guard++;
            if (guard > 60) begin
                checks++;
                errors++;
                $display("FAIL ack_wait: got no Ack after %0d cycles expected Ack", guard);
                break;
            end
            if (CoreRun) begin
                k++;
                CoreHalt = (k == halt_at);
                if (noise) Start = 1'($urandom);
            end else if (Ack) begin
                break;
            end else begin
                CoreHalt = noise ? 1'($urandom) : 1'b0;
            end
        end
        CoreHalt = 1'b0;
        if (!exp_to && model_runs < 255) model_runs++;
        chk("run_length", 32'(k), 32'(exp_ct));
        chk("done_ack", 32'(Ack), 1);
        chk("done_timeout", 32'(Timeout), 32'(exp_to));
        chk("done_cycle_ct", 32'(CycleCt), 32'(exp_ct));
        chk("done_run_count", 32'(RunCount), 32'(model_runs));
        chk("done_core_reset", 32'(CoreReset), 0);
        chk("done_start_pc", 32'(StartPC), 32'(exp_pc));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{sel: 2'd2, halt_at: 5,  exp_pc: 512, exp_ct: 5,    exp_to: 1'b0};
        vecs[1] = '{sel: 2'd0, halt_at: 0,  exp_pc: 0,   exp_ct: MAXC, exp_to: 1'b1};
        vecs[2] = '{sel: 2'd3, halt_at: 20, exp_pc: 768, exp_ct: MAXC, exp_to: 1'b0};
        vecs[3] = '{sel: 2'd1, halt_at: 1,  exp_pc: 256, exp_ct: 1,    exp_to: 1'b0};
        vecs[4] = '{sel: 2'd2, halt_at: 19, exp_pc: 512, exp_ct: 19,   exp_to: 1'b0};
        vecs[5] = '{sel: 2'd1, halt_at: 21, exp_pc: 256, exp_ct: MAXC, exp_to: 1'b1};

        // Reset held two cycles, then released
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk_idle("rst");
        Reset = 1'b0;
        CoreHalt = 1'b1;
        @(negedge Clk);
        chk_idle("rst_rel");
        CoreHalt = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_prog(vecs[i].sel, vecs[i].halt_at, 1'b0,
                     vecs[i].exp_pc, vecs[i].exp_ct, vecs[i].exp_to);
        end

        // Start left high through DONE must not relaunch
        run_prog(2'd0, 7, 1'b0, 0, 7, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("held_ack", 32'(Ack), 1);
            chk("held_core_reset", 32'(CoreReset), 0);
            chk("held_cycle_ct", 32'(CycleCt), 7);
        end
        run_prog(2'd1, 3, 1'b1, 256, 3, 1'b0);

        // Reset in the third RUN cycle after a completed run
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Start  = 1'b1;
        PgmSel = 2'd3;
        repeat (4) @(negedge Clk);
        chk("mid_run_core_run", 32'(CoreRun), 1);
        chk("mid_run_cycle_ct", 32'(CycleCt), 2);
        Reset = 1'b1;
        Start = 1'b0;
        @(negedge Clk);
        model_runs = 0;
        chk_idle("mid_rst");
        Reset = 1'b0;

        // Randomized programs with noise on Start/CoreHalt outside their windows
        for (int i = 0; i < 40; i++) begin
            logic [1:0] s;
            int h;
            int len;
            s   = 2'($urandom);
            h   = int'($urandom_range(0, 25));
            len = (h >= 1 && h <= MAXC) ? h : MAXC;
            run_prog(s, h, 1'($urandom), int'(s) * 256, len, !(h >= 1 && h <= MAXC));
        end

        // Drive RunCount into saturation
        for (int i = 0; i < 260; i++) begin
            run_prog(2'(i), 1, 1'b0, (i % 4) * 256, 1, 1'b0);
        end
        chk("sat_run_count", 32'(RunCount), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
